// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, round-robin
// selection of one slot per cycle onto a registered CDB broadcast.
module cdb_arbiter #(
    parameter  int NUM_FU  = 4,
    parameter  int XLEN    = 32,
    parameter  int ROB_LEN = 8,
    localparam int TAG_W   = $clog2(ROB_LEN),
    localparam int GNT_W   = $clog2(NUM_FU)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     squash_i,
    input  logic [NUM_FU-1:0]        fu_valid_i,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag_i,
    input  logic [NUM_FU*XLEN-1:0]   fu_value_i,
    input  logic [NUM_FU-1:0]        fu_take_branch_i,
    output logic [NUM_FU-1:0]        fu_ready_o,
    output logic                     cdb_valid_o,
    output logic [TAG_W-1:0]         cdb_tag_o,
    output logic [XLEN-1:0]          cdb_value_o,
    output logic                     cdb_take_branch_o,
    output logic [GNT_W-1:0]         cdb_grant_fu_o
);

    logic [NUM_FU-1:0] slot_valid_q, slot_valid_d;
    logic [TAG_W-1:0]  slot_tag_q   [NUM_FU];
    logic [TAG_W-1:0]  slot_tag_d   [NUM_FU];
    logic [XLEN-1:0]   slot_value_q [NUM_FU];
    logic [XLEN-1:0]   slot_value_d [NUM_FU];
    logic [NUM_FU-1:0] slot_tb_q, slot_tb_d;
    logic [GNT_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]   cdb_value_q, cdb_value_d;
    logic              cdb_tb_q, cdb_tb_d;
    logic [GNT_W-1:0]  cdb_grant_q, cdb_grant_d;

    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] fu_ready;
    logic [NUM_FU-1:0] accept;
    logic              any_grant;
    logic [GNT_W-1:0]  grant_idx;
    logic [GNT_W-1:0]  idx;

    // Round-robin search from rr_ptr; squash suppresses any grant.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        grant_idx = '0;
        idx       = '0;
        if (!squash_i) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                idx = GNT_W'((32'(rr_ptr_q) + i) % 32'(NUM_FU));
                if (!any_grant && slot_valid_q[idx]) begin
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                    any_grant  = 1'b1;
                end
            end
        end
    end

    // A granted slot drains this cycle, so it can be refilled in the same cycle.
    assign fu_ready = rst_ni ? ((~slot_valid_q | grant) & {NUM_FU{~squash_i}}) : '1;
    assign accept   = fu_valid_i & fu_ready;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_tag_d   = slot_tag_q;
        slot_value_d = slot_value_q;
        slot_tb_d    = slot_tb_q;
        rr_ptr_d     = rr_ptr_q;
        cdb_valid_d  = any_grant;
        cdb_tag_d    = cdb_tag_q;
        cdb_value_d  = cdb_value_q;
        cdb_tb_d     = cdb_tb_q;
        cdb_grant_d  = cdb_grant_q;

        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_tag_d[i]   = fu_tag_i[i*TAG_W +: TAG_W];
                slot_value_d[i] = fu_value_i[i*XLEN +: XLEN];
                slot_tb_d[i]    = fu_take_branch_i[i];
            end else if (grant[i]) begin
                slot_valid_d[i] = 1'b0;
            end
        end

        if (any_grant) begin
            cdb_tag_d   = slot_tag_q[grant_idx];
            cdb_value_d = slot_value_q[grant_idx];
            cdb_tb_d    = slot_tb_q[grant_idx];
            cdb_grant_d = grant_idx;
            rr_ptr_d    = (grant_idx == GNT_W'(NUM_FU - 1)) ? '0 : grant_idx + GNT_W'(1);
        end

        if (squash_i) begin
            slot_valid_d = '0;
            cdb_valid_d  = 1'b0;
            rr_ptr_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= '0;
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_value_q  <= '0;
            cdb_tb_q     <= 1'b0;
            cdb_grant_q  <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_value_q  <= cdb_value_d;
            cdb_tb_q     <= cdb_tb_d;
            cdb_grant_q  <= cdb_grant_d;
        end
    end

    // Slot payload is qualified by slot_valid_q and needs no reset.
    always_ff @(posedge clk_i) begin
        slot_tag_q   <= slot_tag_d;
        slot_value_q <= slot_value_d;
        slot_tb_q    <= slot_tb_d;
    end

    assign fu_ready_o        = fu_ready;
    assign cdb_valid_o       = cdb_valid_q;
    assign cdb_tag_o         = cdb_tag_q;
    assign cdb_value_o       = cdb_value_q;
    assign cdb_take_branch_o = cdb_tb_q;
    assign cdb_grant_fu_o    = cdb_grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Table-driven bench for cdb_arbiter with a per-FU scoreboard of expected
// broadcasts, plus hand-written reset sequences.
module tb_cdb_arbiter;

    localparam int NFU = 4;
    localparam int XL  = 32;
    localparam int TW  = 3;

    logic            clk;
    logic            rst_n;
    logic            squash;
    logic [NFU-1:0]  fu_valid;
    logic [NFU*TW-1:0] fu_tag;
    logic [NFU*XL-1:0] fu_value;
    logic [NFU-1:0]  fu_tb;
    logic [NFU-1:0]  fu_ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [XL-1:0]   cdb_value;
    logic            cdb_tb;
    logic [1:0]      cdb_grant;

    cdb_arbiter #(.NUM_FU(NFU), .XLEN(XL), .ROB_LEN(8)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .squash_i         (squash),
        .fu_valid_i       (fu_valid),
        .fu_tag_i         (fu_tag),
        .fu_value_i       (fu_value),
        .fu_take_branch_i (fu_tb),
        .fu_ready_o       (fu_ready),
        .cdb_valid_o      (cdb_valid),
        .cdb_tag_o        (cdb_tag),
        .cdb_value_o      (cdb_value),
        .cdb_take_branch_o(cdb_tb),
        .cdb_grant_fu_o   (cdb_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  fv;
        logic [11:0] tg;
        logic        sq;
        logic [3:0]  rdy;
        logic        ev;
        logic [1:0]  eg;
    } vec_t;

    typedef struct {
        int          fu;
        logic [2:0]  tag;
        logic [31:0] val;
        logic        tb;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] last_tag = '0;
    logic [1:0] last_grant = '0;
    vec_t       vt[27];

    function automatic vec_t mk(input logic [3:0] fv, input logic [2:0] t0, input logic [2:0] t1,
                                input logic [2:0] t2, input logic [2:0] t3, input logic sq,
                                input logic [3:0] rdy, input logic ev, input logic [1:0] eg);
        vec_t v;
        v.fv = fv; v.tg = {t3, t2, t1, t0}; v.sq = sq; v.rdy = rdy; v.ev = ev; v.eg = eg;
        return v;
    endfunction

    function automatic logic [31:0] val_of(input int fu, input logic [2:0] tag);
        logic [3:0] f;
        f = 4'(fu);
        return 32'hDEADBEEF ^ {12'h0, f ^ 4'd2, 4'h0, 1'b0, tag ^ 3'd5, 8'h00};
    endfunction

    function automatic logic tb_of(input int fu, input logic [2:0] tag);
        logic [1:0] f;
        f = 2'(fu);
        return ^{f, tag};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input int k, input vec_t v);
        int hit;
        @(negedge clk);
        squash   = v.sq;
        fu_valid = v.fv;
        fu_tag   = v.tg;
        for (int i = 0; i < NFU; i++) begin
            fu_value[i*XL +: XL] = val_of(i, v.tg[i*TW +: TW]);
            fu_tb[i]             = tb_of(i, v.tg[i*TW +: TW]);
        end
        #1;
        chk($sformatf("v%0d fu_ready", k), 64'(fu_ready), 64'(v.rdy));
        if (v.sq) sb.delete();
        for (int i = 0; i < NFU; i++)
            if (v.fv[i] && v.rdy[i])
                sb.push_back('{i, v.tg[i*TW +: TW], val_of(i, v.tg[i*TW +: TW]), tb_of(i, v.tg[i*TW +: TW])});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d cdb_valid", k), 64'(cdb_valid), 64'(v.ev));
        if (v.ev) begin
            chk($sformatf("v%0d grant_fu", k), 64'(cdb_grant), 64'(v.eg));
            hit = -1;
            for (int j = 0; j < sb.size(); j++)
                if (hit < 0 && sb[j].fu == int'(v.eg)) hit = j;
            if (hit < 0) begin
                checks++;
                errors++;
                $display("FAIL v%0d scoreboard: broadcast from fu %0d, expected none pending", k, v.eg);
            end else begin
                chk($sformatf("v%0d cdb_tag", k), 64'(cdb_tag), 64'(sb[hit].tag));
                chk($sformatf("v%0d cdb_value", k), 64'(cdb_value), 64'(sb[hit].val));
                chk($sformatf("v%0d cdb_tb", k), 64'(cdb_tb), 64'(sb[hit].tb));
                last_tag = sb[hit].tag;
                sb.delete(hit);
            end
            last_grant = v.eg;
        end else begin
            chk($sformatf("v%0d tag_hold", k), 64'(cdb_tag), 64'(last_tag));
            chk($sformatf("v%0d grant_hold", k), 64'(cdb_grant), 64'(last_grant));
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " cdb_valid"}, 64'(cdb_valid), 64'd0);
        chk({tag, " cdb_tag"}, 64'(cdb_tag), 64'd0);
        chk({tag, " cdb_value"}, 64'(cdb_value), 64'd0);
        chk({tag, " cdb_tb"}, 64'(cdb_tb), 64'd0);
        chk({tag, " grant_fu"}, 64'(cdb_grant), 64'd0);
        chk({tag, " fu_ready"}, 64'(fu_ready), 64'hF);
    endtask

    initial begin
        // single request, then squash on an empty arbiter to return rr_ptr to 0
        vt[0]  = mk(4'b0100, 0, 0, 5, 0, 0, 4'b1111, 0, 0);
        vt[1]  = mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 1, 2);
        vt[2]  = mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[3]  = mk(4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0);
        // all four FUs at once
        vt[4]  = mk(4'b1111, 1, 2, 3, 4, 0, 4'b1111, 0, 0);
        vt[5]  = mk(4'b0000, 0, 0, 0, 0, 0, 4'b0001, 1, 0);
        vt[6]  = mk(4'b0000, 0, 0, 0, 0, 0, 4'b0011, 1, 1);
        vt[7]  = mk(4'b0000, 0, 0, 0, 0, 0, 4'b0111, 1, 2);
        vt[8]  = mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 1, 3);
        vt[9]  = mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        // FU0 and FU3 contending every cycle
        vt[10] = mk(4'b1001, 1, 0, 0, 2, 0, 4'b1111, 0, 0);
        vt[11] = mk(4'b1001, 3, 0, 0, 4, 0, 4'b0111, 1, 0);
        vt[12] = mk(4'b1001, 5, 0, 0, 4, 0, 4'b1110, 1, 3);
        vt[13] = mk(4'b1001, 5, 0, 0, 6, 0, 4'b0111, 1, 0);
        vt[14] = mk(4'b1000, 0, 0, 0, 6, 0, 4'b1110, 1, 3);
        vt[15] = mk(4'b0000, 0, 0, 0, 0, 0, 4'b0111, 1, 0);
        vt[16] = mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 1, 3);
        vt[17] = mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        // refill of a granted slot
        vt[18] = mk(4'b0010, 0, 2, 0, 0, 0, 4'b1111, 0, 0);
        vt[19] = mk(4'b0010, 0, 6, 0, 0, 0, 4'b1111, 1, 1);
        vt[20] = mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 1, 1);
        vt[21] = mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        // squash with three slots pending, FU2 blocked during the squash
        vt[22] = mk(4'b1011, 1, 3, 0, 7, 0, 4'b1111, 0, 0);
        vt[23] = mk(4'b0100, 0, 0, 5, 0, 1, 4'b0000, 0, 0);
        vt[24] = mk(4'b0100, 0, 0, 5, 0, 0, 4'b1111, 0, 0);
        vt[25] = mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 1, 2);
        vt[26] = mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 0);

        rst_n    = 1'b0;
        squash   = 1'b1;
        fu_valid = '1;
        fu_tag   = '0;
        fu_value = '0;
        fu_tb    = '0;
        #12;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n    = 1'b1;
        squash   = 1'b0;
        fu_valid = '0;

        for (int k = 0; k < 27; k++) apply(k, vt[k]);
        chk("table sb_drained", 64'(sb.size()), 64'd0);

        // asynchronous reset in mid-cycle with two slots pending
        apply(100, mk(4'b0011, 2, 3, 0, 0, 0, 4'b1111, 0, 0));
        apply(101, mk(4'b0000, 0, 0, 0, 0, 0, 4'b1101, 1, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        sb.delete();
        last_tag   = '0;
        last_grant = '0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(102, mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 0));
        apply(103, mk(4'b0010, 0, 4, 0, 0, 0, 4'b1111, 0, 0));
        apply(104, mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 1, 1));
        apply(105, mk(4'b0000, 0, 0, 0, 0, 0, 4'b1111, 0, 0));
        chk("final sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
